// File: rtl/sram_multiport_pkg.sv
// ----------------------------------------------------------------------------
// sram_multiport_pkg
//   Shared memory constants for the multi-port register-file SRAM.
//   Default geometry: 8192 words, 13-bit addresses. Data widths used by the
//   system: 8 (input image), 16 (output), 128 (graph / working memory).
//   mem_index_width() gives the array index width needed for a given depth.
// ----------------------------------------------------------------------------
package sram_multiport_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 13;
    localparam int unsigned MEM_DEPTH      = 8192;
    localparam int unsigned MEM_IN_WIDTH   = 8;
    localparam int unsigned MEM_OUT_WIDTH  = 16;
    localparam int unsigned MEM_WORK_WIDTH = 128;

    // Bits needed to index DEPTH words (at least one bit).
    function automatic int unsigned mem_index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_multiport_if.sv
// ----------------------------------------------------------------------------
// sram_multiport_if
//   Bundle of the memory's bus signals (one write port, two read ports).
//   master : drives write enable/address/data and read addresses, samples
//            read data.
//   slave  : the memory side.
//   Clock and reset are kept as plain module ports.
// ----------------------------------------------------------------------------
interface sram_multiport_if #(
    parameter int unsigned DATA_WIDTH = sram_multiport_pkg::MEM_WORK_WIDTH,
    parameter int unsigned ADDR_WIDTH = sram_multiport_pkg::MEM_ADDR_WIDTH
) ();

    logic                  WE;
    logic [ADDR_WIDTH-1:0] WriteAddress;
    logic [DATA_WIDTH-1:0] WriteBus;
    logic [ADDR_WIDTH-1:0] ReadAddress1;
    logic [DATA_WIDTH-1:0] ReadBus1;
    logic [ADDR_WIDTH-1:0] ReadAddress2;
    logic [DATA_WIDTH-1:0] ReadBus2;

    modport master (
        output WE, WriteAddress, WriteBus, ReadAddress1, ReadAddress2,
        input  ReadBus1, ReadBus2
    );

    modport slave (
        input  WE, WriteAddress, WriteBus, ReadAddress1, ReadAddress2,
        output ReadBus1, ReadBus2
    );

endinterface

// File: rtl/sram_multiport.sv
// ----------------------------------------------------------------------------
// sram_multiport
//   Flat register-file memory: one synchronous write port, one or two
//   asynchronous (combinational) read ports. Storage is the array Register,
//   left uninitialised so benches can preload/dump it directly.
//
//   Ports
//     clock         in   rising-edge clock
//     reset         in   synchronous active-high; only blocks writes
//     WE            in   write enable (ignored when HAS_WRITE=0)
//     WriteAddress  in   write word address
//     WriteBus      in   write data
//     ReadAddress1  in   read port 1 address
//     ReadBus1      out  Register[ReadAddress1], zero if out of range
//     ReadAddress2  in   read port 2 address (ignored when NUM_READ=1)
//     ReadBus2      out  Register[ReadAddress2], zero if out of range or
//                        when NUM_READ=1
//
//   Addresses >= DEPTH read as zero and are never written. Reads do not
//   bypass the write port: a read of the address being written shows the
//   old word until the clock edge.
// ----------------------------------------------------------------------------
module sram_multiport
    import sram_multiport_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MEM_WORK_WIDTH,
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = MEM_DEPTH,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned HAS_WRITE  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WriteAddress,
    input  logic [DATA_WIDTH-1:0] WriteBus,
    input  logic [ADDR_WIDTH-1:0] ReadAddress1,
    output logic [DATA_WIDTH-1:0] ReadBus1,
    input  logic [ADDR_WIDTH-1:0] ReadAddress2,
    output logic [DATA_WIDTH-1:0] ReadBus2
);

    localparam int unsigned IDX_W = mem_index_width(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] Register [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Read port 1
    // ------------------------------------------------------------------
    logic                  w_rd1_ok;
    logic [IDX_W-1:0]      w_rd1_idx;
    logic [DATA_WIDTH-1:0] w_rd1_data;

    // Range check uses the full address; the index drops bits that are
    // only meaningful for out-of-range addresses.
    assign w_rd1_ok  = ({1'b0, ReadAddress1} < LP_DEPTH);
    assign w_rd1_idx = ReadAddress1[IDX_W-1:0];

    always_comb begin
        w_rd1_data = '0;
        if (w_rd1_ok) begin
            w_rd1_data = Register[w_rd1_idx];
        end
    end

    assign ReadBus1 = w_rd1_data;

    // ------------------------------------------------------------------
    // Read port 2
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd2_data;

    if (NUM_READ >= 2) begin : g_rd2
        logic             w_rd2_ok;
        logic [IDX_W-1:0] w_rd2_idx;

        assign w_rd2_ok  = ({1'b0, ReadAddress2} < LP_DEPTH);
        assign w_rd2_idx = ReadAddress2[IDX_W-1:0];

        always_comb begin
            w_rd2_data = '0;
            if (w_rd2_ok) begin
                w_rd2_data = Register[w_rd2_idx];
            end
        end
    end else begin : g_rd2_off
        logic w_unused_rd2;

        assign w_unused_rd2 = ^ReadAddress2;
        assign w_rd2_data   = '0;
    end

    assign ReadBus2 = w_rd2_data;

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    if (HAS_WRITE != 0) begin : g_write
        logic             w_wr_ok;
        logic [IDX_W-1:0] w_wr_idx;

        assign w_wr_ok  = ({1'b0, WriteAddress} < LP_DEPTH);
        assign w_wr_idx = WriteAddress[IDX_W-1:0];

        // Reset gates the write but never clears the array.
        always_ff @(posedge clock) begin
            if (!reset && WE && w_wr_ok) begin
                Register[w_wr_idx] <= WriteBus;
            end
        end
    end else begin : g_write_off
        logic w_unused_wr;

        assign w_unused_wr = ^{clock, reset, WE, WriteAddress, WriteBus};
    end

endmodule

// File: tb/tb_sram_multiport.sv
// ----------------------------------------------------------------------------
// tb_sram_multiport
//   Bench for sram_multiport. Four instances cover the parameter space:
//     u_main : 128-bit, 8192 words, two read ports, writable
//     u_16   : 16-bit, one read port
//     u_ro   : 8-bit, read-only (preloaded through the Register array)
//     u_4k   : 8-bit, DEPTH=4096 with 13-bit addresses
//   u_main is additionally driven with random traffic and compared every
//   half cycle against an array model of the memory.
// ----------------------------------------------------------------------------
module tb_sram_multiport;
    import sram_multiport_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    sram_multiport_if #(.DATA_WIDTH(128), .ADDR_WIDTH(13)) bm  ();
    sram_multiport_if #(.DATA_WIDTH(16),  .ADDR_WIDTH(13)) b16 ();
    sram_multiport_if #(.DATA_WIDTH(8),   .ADDR_WIDTH(13)) bro ();
    sram_multiport_if #(.DATA_WIDTH(8),   .ADDR_WIDTH(13)) b4k ();

    sram_multiport #(.DATA_WIDTH(128), .ADDR_WIDTH(13), .DEPTH(8192),
                     .NUM_READ(2), .HAS_WRITE(1)) u_main (
        .clock(clk), .reset(rst), .WE(bm.WE), .WriteAddress(bm.WriteAddress),
        .WriteBus(bm.WriteBus), .ReadAddress1(bm.ReadAddress1), .ReadBus1(bm.ReadBus1),
        .ReadAddress2(bm.ReadAddress2), .ReadBus2(bm.ReadBus2)
    );

    sram_multiport #(.DATA_WIDTH(16), .ADDR_WIDTH(13), .DEPTH(8192),
                     .NUM_READ(1), .HAS_WRITE(1)) u_16 (
        .clock(clk), .reset(rst), .WE(b16.WE), .WriteAddress(b16.WriteAddress),
        .WriteBus(b16.WriteBus), .ReadAddress1(b16.ReadAddress1), .ReadBus1(b16.ReadBus1),
        .ReadAddress2(b16.ReadAddress2), .ReadBus2(b16.ReadBus2)
    );

    sram_multiport #(.DATA_WIDTH(8), .ADDR_WIDTH(13), .DEPTH(8192),
                     .NUM_READ(2), .HAS_WRITE(0)) u_ro (
        .clock(clk), .reset(rst), .WE(bro.WE), .WriteAddress(bro.WriteAddress),
        .WriteBus(bro.WriteBus), .ReadAddress1(bro.ReadAddress1), .ReadBus1(bro.ReadBus1),
        .ReadAddress2(bro.ReadAddress2), .ReadBus2(bro.ReadBus2)
    );

    sram_multiport #(.DATA_WIDTH(8), .ADDR_WIDTH(13), .DEPTH(4096),
                     .NUM_READ(2), .HAS_WRITE(1)) u_4k (
        .clock(clk), .reset(rst), .WE(b4k.WE), .WriteAddress(b4k.WriteAddress),
        .WriteBus(b4k.WriteBus), .ReadAddress1(b4k.ReadAddress1), .ReadBus1(b4k.ReadBus1),
        .ReadAddress2(b4k.ReadAddress2), .ReadBus2(b4k.ReadBus2)
    );

    // ------------------------------------------------------------------
    // Checking helpers and reference model of u_main
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Preload pattern for the read-only instance.
    function automatic logic [7:0] ro_byte(input int unsigned a);
        return 8'((a * 37 + 11) % 256);
    endfunction

    logic [127:0] m_mem   [0:8191];
    bit           m_known [0:8191];
    bit           run = 1'b0;

    function automatic logic [12:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 13'd0;
            1:       return 13'd8191;
            default: return 13'(4080 + $urandom_range(0, 31));
        endcase
    endfunction

    task automatic cmp_reads(input string tag);
        int unsigned a1 = bm.ReadAddress1;
        int unsigned a2 = bm.ReadAddress2;
        if (m_known[a1]) check({tag, "_main_rd1"}, bm.ReadBus1, m_mem[a1]);
        if (m_known[a2]) check({tag, "_main_rd2"}, bm.ReadBus2, m_mem[a2]);
    endtask

    // Model: a write lands at the edge when enabled and reset is low;
    // reads are checked just after each edge (new data) and just after
    // inputs change at the falling edge (contents before the next edge).
    initial begin : compare
        forever begin
            @(posedge clk);
            if (run) begin
                if (!rst && bm.WE) begin
                    m_mem[bm.WriteAddress]   = bm.WriteBus;
                    m_known[bm.WriteAddress] = 1'b1;
                end
                #1 cmp_reads("post");
            end
            @(negedge clk);
            if (run) begin
                #1 cmp_reads("pre");
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [12:0] ro_hits [$];
    localparam logic [127:0] VAL_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] VAL_B = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1357_9BDF;

    task automatic main_write(input logic [12:0] a, input logic [127:0] d);
        @(negedge clk);
        bm.WE = 1'b1; bm.WriteAddress = a; bm.WriteBus = d;
        bm.ReadAddress1 = a; bm.ReadAddress2 = 13'(a - 1);
        @(posedge clk);
    endtask

    task automatic w16(input logic [12:0] a, input logic [15:0] d);
        @(negedge clk);
        b16.WE = 1'b1; b16.WriteAddress = a; b16.WriteBus = d;
        @(posedge clk);
    endtask

    task automatic w4k(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        b4k.WE = 1'b1; b4k.WriteAddress = a; b4k.WriteBus = d;
        @(posedge clk);
    endtask

    initial begin : stim
        rst = 1'b1;
        bm.WE = 1'b0;  bm.WriteAddress = '0;  bm.WriteBus = '0;  bm.ReadAddress1 = '0;  bm.ReadAddress2 = '0;
        b16.WE = 1'b0; b16.WriteAddress = '0; b16.WriteBus = '0; b16.ReadAddress1 = '0; b16.ReadAddress2 = '0;
        bro.WE = 1'b0; bro.WriteAddress = '0; bro.WriteBus = '0; bro.ReadAddress1 = '0; bro.ReadAddress2 = '0;
        b4k.WE = 1'b0; b4k.WriteAddress = '0; b4k.WriteBus = '0; b4k.ReadAddress1 = '0; b4k.ReadAddress2 = '0;
        for (int i = 0; i < 8192; i++) m_known[i] = 1'b0;

        // Time-0 preload of the read-only instance with reset asserted.
        for (int i = 0; i < 8192; i++) u_ro.Register[i] = ro_byte(i);
        bro.ReadAddress1 = 13'd5;
        bro.ReadAddress2 = 13'd8191;
        #1;
        check("ro_preload_rd1", bro.ReadBus1, 128'(ro_byte(5)));
        check("ro_preload_rd2", bro.ReadBus2, 128'(ro_byte(8191)));
        repeat (2) @(posedge clk);
        #1;
        check("ro_after_reset", bro.ReadBus1, 128'(ro_byte(5)));
        @(negedge clk);
        rst = 1'b0;

        // 16-bit, single read port
        w16(13'd5, 16'h1234);
        w16(13'd100, 16'h0BAD);
        @(negedge clk);
        b16.WE = 1'b0; b16.ReadAddress1 = 13'd5; b16.ReadAddress2 = 13'd5;
        #1;
        check("w16_comb_read", b16.ReadBus1, 128'h1234);
        check("w16_rd2_tied_zero", b16.ReadBus2, 128'h0);
        // Write 100 with the read port on 100: old before the edge, new after.
        @(negedge clk);
        b16.WE = 1'b1; b16.WriteAddress = 13'd100; b16.WriteBus = 16'hFFFF; b16.ReadAddress1 = 13'd100;
        #1 check("w16_before_edge", b16.ReadBus1, 128'h0BAD);
        @(posedge clk);
        #1 check("w16_after_edge", b16.ReadBus1, 128'hFFFF);
        // Same kind of write under reset is blocked.
        @(negedge clk);
        rst = 1'b1; b16.WriteBus = 16'h5555;
        @(posedge clk);
        #1 check("w16_reset_blocks", b16.ReadBus1, 128'hFFFF);
        @(negedge clk);
        rst = 1'b0; b16.WE = 1'b0; b16.ReadAddress1 = 13'd5;
        #1 check("w16_reset_keeps_5", b16.ReadBus1, 128'h1234);
        // First edge after reset release writes normally.
        @(negedge clk);
        b16.WE = 1'b1; b16.WriteAddress = 13'd100; b16.WriteBus = 16'h7777; b16.ReadAddress1 = 13'd100;
        @(posedge clk);
        #1 check("w16_after_release", b16.ReadBus1, 128'h7777);
        @(negedge clk);
        b16.WE = 1'b0;

        // Read-only instance: write enable toggling must not change anything.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bro.WE = (i % 2 == 0);
            bro.WriteAddress = 13'($urandom_range(0, 8191));
            bro.WriteBus = ~ro_byte(bro.WriteAddress);
            ro_hits.push_back(bro.WriteAddress);
        end
        @(negedge clk);
        bro.WE = 1'b0;
        ro_hits.push_back(13'd0);
        ro_hits.push_back(13'd8191);
        for (int k = 0; k < ro_hits.size(); k++) begin
            bro.ReadAddress1 = ro_hits[k];
            bro.ReadAddress2 = ro_hits[(k + 1) % ro_hits.size()];
            #1;
            check("ro_hold_rd1", bro.ReadBus1, 128'(ro_byte(ro_hits[k])));
            check("ro_hold_rd2", bro.ReadBus2, 128'(ro_byte(ro_hits[(k + 1) % ro_hits.size()])));
        end

        // DEPTH=4096: out-of-range writes dropped, reads return zero.
        w4k(13'd904,  8'h11);
        w4k(13'd4095, 8'h22);
        w4k(13'd0,    8'h33);
        w4k(13'd5000, 8'hAA);
        w4k(13'd4096, 8'hBB);
        @(negedge clk);
        b4k.WE = 1'b0; b4k.ReadAddress1 = 13'd5000; b4k.ReadAddress2 = 13'd904;
        #1;
        check("d4k_read_5000", b4k.ReadBus1, 128'h0);
        check("d4k_alias_904", b4k.ReadBus2, 128'h11);
        b4k.ReadAddress1 = 13'd4095; b4k.ReadAddress2 = 13'd0;
        #1;
        check("d4k_top_word", b4k.ReadBus1, 128'h22);
        check("d4k_word0", b4k.ReadBus2, 128'h33);
        b4k.ReadAddress1 = 13'd4096; b4k.ReadAddress2 = 13'd8191;
        #1;
        check("d4k_read_4096", b4k.ReadBus1, 128'h0);
        check("d4k_read_8191", b4k.ReadBus2, 128'h0);

        // Main instance: fill the address window, then the two-port corners.
        run = 1'b1;
        for (int a = 4080; a < 4112; a++)
            main_write(13'(a), {$urandom(), $urandom(), $urandom(), $urandom()});
        main_write(13'd0, VAL_A);
        main_write(13'd8191, VAL_B);
        @(negedge clk);
        bm.WE = 1'b0; bm.ReadAddress1 = 13'd0; bm.ReadAddress2 = 13'd8191;
        #1;
        check("main_rd1_word0", bm.ReadBus1, VAL_A);
        check("main_rd2_word8191", bm.ReadBus2, VAL_B);
        bm.ReadAddress1 = 13'd8191;
        #1;
        check("main_same_addr_rd1", bm.ReadBus1, VAL_B);
        check("main_same_addr_rd2", bm.ReadBus2, VAL_B);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 9) == 0);
            bm.WE = ($urandom_range(0, 2) != 0);
            bm.WriteAddress = pick_addr();
            bm.WriteBus = {$urandom(), $urandom(), $urandom(), $urandom()};
            bm.ReadAddress1 = ($urandom_range(0, 3) == 0) ? bm.WriteAddress : pick_addr();
            bm.ReadAddress2 = ($urandom_range(0, 3) == 0) ? bm.ReadAddress1 : pick_addr();
        end
        @(posedge clk);
        #2;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bm.WE = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_multiport.md
SRAM_MULTIPORT -- requirements
Module: sram_multiport

Interface
REQ-001 Parameter DATA_WIDTH, default 128: word width in bits; the system uses 8 (input), 16 (output) and 128 (graph/working).
REQ-002 Parameter ADDR_WIDTH, default 13: address width in bits.
REQ-003 Parameter DEPTH, default 8192: number of words, at most 2**ADDR_WIDTH.
REQ-004 Parameter NUM_READ, default 2, legal values 1 or 2: number of active read ports.
REQ-005 Parameter HAS_WRITE, default 1, legal values 0 or 1: write port present.
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 Port list (name, direction, width, meaning):
- clock  in  1  sole clock; rising edge is active.
- reset  in  1  synchronous, active-high; blocks writes only.
- WE  in  1  write enable; ignored when HAS_WRITE=0.
- WriteAddress  in  ADDR_WIDTH  write word address.
- WriteBus  in  DATA_WIDTH  write data.
- ReadAddress1  in  ADDR_WIDTH  read port 1 address.
- ReadBus1  out  DATA_WIDTH  read port 1 data.
- ReadAddress2  in  ADDR_WIDTH  read port 2 address; ignored when NUM_READ=1.
- ReadBus2  out  DATA_WIDTH  read port 2 data; driven to all zeros when NUM_READ=1.
REQ-008 The storage array SHALL be named Register, declared [0:DEPTH-1] of DATA_WIDTH bits, so benches can preload it with $readmemh and dump it with $writememh.

Function
REQ-009 Reads SHALL be asynchronous and combinational: ReadBusN = Register[ReadAddressN] in the same cycle, with zero clock latency.
REQ-010 Two read ports SHALL be fully independent; the same address on both ports SHALL return identical data.
REQ-011 Write: at the rising clock edge, if HAS_WRITE=1, WE=1 and reset=0, Register[WriteAddress] SHALL take the value of WriteBus.
REQ-012 With WE=0, or HAS_WRITE=0, the array SHALL hold its contents indefinitely.
REQ-013 Read during write to the same address: the read bus SHALL show the old data before the edge and the new data immediately after the edge (no bypass).
REQ-014 Addresses >= DEPTH: reads SHALL return all zeros and writes SHALL be dropped. With the defaults every address is in range.
REQ-015 There is no handshake, no busy signal and no state machine; every write completes in one cycle.
REQ-016 Contents SHALL be X in simulation until preloaded or written; no initial clear is performed.

Reset
REQ-017 Reset SHALL NOT clear Register, so contents preloaded at time 0 survive a reset asserted at time 0.
REQ-018 While reset=1, writes SHALL be suppressed and reads SHALL remain functional.
REQ-019 Deasserting reset mid-operation SHALL take effect at the next rising edge, with no other side effects.
REQ-020 Outputs have no reset value of their own; they always reflect the array contents (or zeros per REQ-007 and REQ-014).

Structure
REQ-021 Default widths (ADDR_WIDTH=13, DEPTH=8192, data widths 8/16/128) SHALL live as named constants in the shared memory package.
REQ-022 The design SHALL be a single flat module with no sub-modules.
- Read-only variants (HAS_WRITE=0) and single-read variants (NUM_READ=1) SHALL be configured by parameters, not separate RTL.

Verification
REQ-023 Preload Register[5]=16'h1234 with HAS_WRITE=1 and NUM_READ=1, ReadAddress1=5 -> ReadBus1=16'h1234 combinationally, with no clock edge.
REQ-024 Write with WE=1, WriteAddress=100, WriteBus=16'hFFFF, reset=0, one rising edge -> ReadBus1 at address 100 reads 16'hFFFF after the edge and the old value before it.
REQ-025 Same write as REQ-024 with reset=1 -> address 100 unchanged; after deasserting reset, preloaded Register[5] still reads 16'h1234.
REQ-026 DATA_WIDTH=128, NUM_READ=2, preload [0]=A and [8191]=B, ReadAddress1=0, ReadAddress2=8191 -> ReadBus1=A and ReadBus2=B simultaneously; both ports at 8191 -> both read B.
REQ-027 HAS_WRITE=0, DATA_WIDTH=8, WE=1 toggled for 10 cycles -> every preloaded byte is unchanged.
REQ-028 DEPTH=4096, ADDR_WIDTH=13, write 0xAA to address 5000 -> no array word changes, and a read at 5000 returns 0.
